// File: rtl/fm_modulate.sv
// -----------------------------------------------------------------------------
// fm_modulate
//   FM modulator for the return voice link. Each accepted audio sample advances
//   a phase accumulator by LO_fre + audio*dev_gain, then an iterative
//   rotate-mode CORDIC turns a constant-amplitude vector through that phase to
//   produce one complex baseband I/Q sample.
//
// Ports
//   clk_in       system clock, rising edge
//   RST          asynchronous active-high reset
//   LO_fre       carrier/offset frequency word (sampled at accept)
//   dev_gain     unsigned deviation gain (sampled at accept)
//   phase_clr    zero the accumulator before adding (sampled at accept)
//   audio_in     signed audio sample
//   audio_valid  audio_in valid
//   audio_ready  block idle and able to take a sample
//   I_OUT/Q_OUT  signed saturated baseband output, held between samples
//   out_valid    one-cycle strobe marking a new I_OUT/Q_OUT
// -----------------------------------------------------------------------------
module fm_modulate #(
    parameter int INPUT_WIDTH = 12,
    parameter int IQ_WIDTH    = 12,
    parameter int PH_BITS     = 32,
    parameter int ITERATIONS  = 16,
    parameter int AMPLITUDE   = 1243
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic [PH_BITS-1:0]     LO_fre,
    input  logic [15:0]            dev_gain,
    input  logic                   phase_clr,
    input  logic [INPUT_WIDTH-1:0] audio_in,
    input  logic                   audio_valid,
    output logic                   audio_ready,
    output logic [IQ_WIDTH-1:0]    I_OUT,
    output logic [IQ_WIDTH-1:0]    Q_OUT,
    output logic                   out_valid
);

    localparam int XW = IQ_WIDTH + 2;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic signed [XW-1:0] AMP    = XW'(AMPLITUDE);
    localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (IQ_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_LO = -SAT_HI;

    // The atan table is held at 32-bit angle precision and rescaled to PH_BITS.
    localparam int SH_UP = (PH_BITS >= 32) ? PH_BITS - 32 : 0;
    localparam int SH_DN = (PH_BITS < 32) ? 32 - PH_BITS : 0;
    localparam logic [63:0] RND = (64'd1 << SH_DN) >> 1;

    typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_t;

    // round(atan(2^-i) / (2*pi) * 2^32)
    function automatic logic [PH_BITS-1:0] atan_lut(input logic [CW-1:0] idx);
        logic [63:0] base;
        logic [63:0] scaled;
        case (32'(idx))
            0:  base = 64'd536870912;
            1:  base = 64'd316933406;
            2:  base = 64'd167458907;
            3:  base = 64'd85004756;
            4:  base = 64'd42667331;
            5:  base = 64'd21354465;
            6:  base = 64'd10679838;
            7:  base = 64'd5340245;
            8:  base = 64'd2670163;
            9:  base = 64'd1335087;
            10: base = 64'd667544;
            11: base = 64'd333772;
            12: base = 64'd166886;
            13: base = 64'd83443;
            14: base = 64'd41722;
            15: base = 64'd20861;
            16: base = 64'd10430;
            17: base = 64'd5215;
            18: base = 64'd2608;
            19: base = 64'd1304;
            20: base = 64'd652;
            21: base = 64'd326;
            22: base = 64'd163;
            23: base = 64'd81;
            24: base = 64'd41;
            25: base = 64'd20;
            26: base = 64'd10;
            27: base = 64'd5;
            28: base = 64'd3;
            29: base = 64'd1;
            default: base = 64'd0;
        endcase
        scaled = ((base << SH_UP) + RND) >> SH_DN;
        return scaled[PH_BITS-1:0];
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic [IQ_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_HI)      return SAT_HI[IQ_WIDTH-1:0];
        else if (v < SAT_LO) return SAT_LO[IQ_WIDTH-1:0];
        else                 return v[IQ_WIDTH-1:0];
    endfunction

    state_t                     state_q, state_d;
    logic [PH_BITS-1:0]         phase_q, phase_d;
    logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
    logic signed [PH_BITS-1:0]  z_q, z_d;
    logic [CW-1:0]              iter_q, iter_d;
    logic [IQ_WIDTH-1:0]        i_out_q, i_out_d, q_out_q, q_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       ready_q, ready_d;

    logic                       accept;
    logic signed [PH_BITS-1:0]  audio_ext, gain_ext, prod;
    logic [PH_BITS-1:0]         fw;
    logic signed [XW-1:0]       x_sh, y_sh;
    logic signed [PH_BITS-1:0]  atan_i;

    assign accept = audio_valid & ready_q;

    // The true product fits in INPUT_WIDTH+16 signed bits, so a PH_BITS-wide
    // multiply of the extended operands equals the sign-extended product.
    assign audio_ext = PH_BITS'($signed(audio_in));
    assign gain_ext  = PH_BITS'(dev_gain);
    assign prod      = audio_ext * gain_ext;
    assign fw        = LO_fre + $unsigned(prod);

    assign x_sh   = x_q >>> iter_q;
    assign y_sh   = y_q >>> iter_q;
    assign atan_i = $signed(atan_lut(iter_q));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    phase_d = (phase_clr ? '0 : phase_q) + fw;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Fold quadrants 2/3 onto 0/1 by starting from -AMPLITUDE and
                // taking 180 degrees off the angle.
                if (phase_q[PH_BITS-1] ^ phase_q[PH_BITS-2]) begin
                    x_d = -AMP;
                    z_d = {~phase_q[PH_BITS-1], phase_q[PH_BITS-2:0]};
                end else begin
                    x_d = AMP;
                    z_d = phase_q;
                end
                y_d     = '0;
                iter_d  = '0;
                state_d = ROT;
            end
            ROT: begin
                if (!z_q[PH_BITS-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == CW'(ITERATIONS - 1)) begin
                    // Outputs register on the last micro-rotation so they are
                    // already valid during DONE.
                    i_out_d     = sat(x_d);
                    q_out_d     = sat(y_d);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign audio_ready = ready_q;
    assign I_OUT       = i_out_q;
    assign Q_OUT       = q_out_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fm_modulate.sv
// -----------------------------------------------------------------------------
// tb_fm_modulate
//   Directed, table-driven bench for fm_modulate. Expected I/Q values are the
//   ideal rotated vector (full scale ~2047); truncating CORDIC shifts leave a
//   few LSB of error, so I/Q comparisons carry a tolerance.
// -----------------------------------------------------------------------------
module tb_fm_modulate;

    logic        clk_in = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] LO_fre = '0;
    logic [15:0] dev_gain = '0;
    logic        phase_clr = 1'b0;
    logic [11:0] audio_in = '0;
    logic        audio_valid = 1'b0;
    logic        audio_ready;
    logic [11:0] I_OUT, Q_OUT;
    logic        out_valid;

    fm_modulate dut (
        .clk_in      (clk_in),
        .RST         (RST),
        .LO_fre      (LO_fre),
        .dev_gain    (dev_gain),
        .phase_clr   (phase_clr),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .I_OUT       (I_OUT),
        .Q_OUT       (Q_OUT),
        .out_valid   (out_valid)
    );

    always #5 clk_in = ~clk_in;

    localparam int TOL = 8;
    localparam int LAT = 17;   // edges after the accept edge: out_valid in cycle k+18

    typedef struct {
        logic [31:0] lo;
        logic [15:0] gain;
        logic [11:0] audio;
        logic        clr;
        int          ei;
        int          eq;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   ov_count = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic void ideal(input longint ph, output int ei, output int eq);
        real a;
        a  = 6.283185307179586 * real'(ph) / 4294967296.0;
        ei = rnd(2046.92 * $cos(a));
        eq = rnd(2046.92 * $sin(a));
    endfunction

    // Output-side invariants checked on every strobe.
    always @(negedge clk_in) begin
        if (out_valid) begin
            ov_count++;
            chk(prev_ov == 1'b0, "out_valid_single_cycle", int'(prev_ov), 0);
            chk(I_OUT != 12'h800 && Q_OUT != 12'h800, "no_most_negative_code",
                int'($signed(I_OUT)), -2047);
        end
        prev_ov = out_valid;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!audio_ready && n < 40) begin
            step();
            n++;
        end
        chk(audio_ready == 1'b1, "ready_within_budget", int'(audio_ready), 1);
    endtask

    task automatic run_sample(input vec_t v, output int ri, output int rq, output int lat);
        wait_ready();
        LO_fre      = v.lo;
        dev_gain    = v.gain;
        audio_in    = v.audio;
        phase_clr   = v.clr;
        audio_valid = 1'b1;
        step();
        // Garbage while busy must not matter.
        audio_valid = 1'b0;
        LO_fre      = $urandom;
        dev_gain    = 16'($urandom);
        audio_in    = 12'($urandom);
        phase_clr   = 1'($urandom);
        chk(audio_ready == 1'b0, "ready_low_after_accept", int'(audio_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        ri = int'($signed(I_OUT));
        rq = int'($signed(Q_OUT));
    endtask

    vec_t tbl[11];
    vec_t v;
    int   ri, rq, lat, ei, eq, ov_before;
    longint ph;
    int   acc_cyc[$];
    int   oi[$];
    int   oq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 90-degree steps from LO alone, wrap, the same step built from
        // LO + audio*gain, phase_clr, and a large negative deviation.
        tbl[0]  = '{32'd0,         16'd0,     12'd0,    1'b1,  2047,     0};
        tbl[1]  = '{32'h4000_0000, 16'd0,     12'd0,    1'b0,     0,  2047};
        tbl[2]  = '{32'h4000_0000, 16'd0,     12'd0,    1'b0, -2047,     0};
        tbl[3]  = '{32'h4000_0000, 16'd0,     12'd0,    1'b0,     0, -2047};
        tbl[4]  = '{32'h4000_0000, 16'd0,     12'd0,    1'b0,  2047,     0};
        tbl[5]  = '{32'h3F00_0000, 16'd32768, 12'd512,  1'b0,     0,  2047};
        tbl[6]  = '{32'h3F00_0000, 16'd32768, 12'd512,  1'b0, -2047,     0};
        tbl[7]  = '{32'h3F00_0000, 16'd32768, 12'd512,  1'b0,     0, -2047};
        tbl[8]  = '{32'h3F00_0000, 16'd32768, 12'd512,  1'b0,  2047,     0};
        tbl[9]  = '{32'h4000_0000, 16'd0,     12'd0,    1'b1,     0,  2047};
        // -2048*65535 = -(2^27 - 2048): about -11.25 degrees
        tbl[10] = '{32'd0,         16'd65535, 12'h800,  1'b1,  2008,  -399};

        // Asynchronous reset without a clock edge.
        #2 RST = 1'b1;
        #1;
        chk(I_OUT == 12'd0, "reset_I", int'($signed(I_OUT)), 0);
        chk(Q_OUT == 12'd0, "reset_Q", int'($signed(Q_OUT)), 0);
        chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
        chk(audio_ready == 1'b0, "reset_ready", int'(audio_ready), 0);
        step();
        chk(audio_ready == 1'b0, "ready_low_in_reset", int'(audio_ready), 0);
        #2 RST = 1'b0;
        step();
        chk(audio_ready == 1'b1, "ready_after_release", int'(audio_ready), 1);

        for (int k = 0; k < 11; k++) begin
            run_sample(tbl[k], ri, rq, lat);
            chk(lat == LAT, $sformatf("latency[%0d]", k), lat, LAT);
            chk_tol($sformatf("I[%0d]", k), ri, tbl[k].ei, TOL);
            chk_tol($sformatf("Q[%0d]", k), rq, tbl[k].eq, TOL);
        end

        // Negative deviation: fw = 2^30 - 2^25, compared to the ideal vector.
        ph = 0;
        for (int k = 0; k < 4; k++) begin
            v = '{32'h3F00_0000, 16'd32768, 12'hE00, (k == 0), 0, 0};
            run_sample(v, ri, rq, lat);
            ph = (ph + 64'd1040187392) & 64'hFFFF_FFFF;
            ideal(ph, ei, eq);
            chk_tol($sformatf("neg_dev_I[%0d]", k), ri, ei, TOL);
            chk_tol($sformatf("neg_dev_Q[%0d]", k), rq, eq, TOL);
        end

        // audio_valid held high: one accept per 19 cycles, busy samples ignored.
        wait_ready();
        audio_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (audio_ready && acc_cyc.size() < 4) begin
                LO_fre    = 32'h4000_0000;
                dev_gain  = 16'd0;
                audio_in  = 12'd0;
                phase_clr = (acc_cyc.size() == 0);
                acc_cyc.push_back(c);
            end else if (audio_ready) begin
                audio_valid = 1'b0;
            end else begin
                LO_fre    = $urandom;
                dev_gain  = 16'($urandom);
                audio_in  = 12'($urandom);
                phase_clr = 1'($urandom);
            end
            if (out_valid) begin
                oi.push_back(int'($signed(I_OUT)));
                oq.push_back(int'($signed(Q_OUT)));
            end
            step();
        end
        audio_valid = 1'b0;
        chk(acc_cyc.size() == 4, "stream_accepts", acc_cyc.size(), 4);
        for (int k = 1; k < acc_cyc.size(); k++)
            chk(acc_cyc[k] - acc_cyc[k-1] == 19, $sformatf("stream_period[%0d]", k),
                acc_cyc[k] - acc_cyc[k-1], 19);
        chk(oi.size() == 4, "stream_outputs", oi.size(), 4);
        if (oi.size() == 4) begin
            chk_tol("stream_I0", oi[0], 0, TOL);      chk_tol("stream_Q0", oq[0], 2047, TOL);
            chk_tol("stream_I1", oi[1], -2047, TOL);  chk_tol("stream_Q1", oq[1], 0, TOL);
            chk_tol("stream_I2", oi[2], 0, TOL);      chk_tol("stream_Q2", oq[2], -2047, TOL);
            chk_tol("stream_I3", oi[3], 2047, TOL);   chk_tol("stream_Q3", oq[3], 0, TOL);
        end

        // Reset pulse mid-rotation: aborted sample never strobes and the
        // accumulator restarts from zero.
        wait_ready();
        LO_fre = 32'h4000_0000; dev_gain = 16'd0; audio_in = 12'd0; phase_clr = 1'b0;
        audio_valid = 1'b1;
        step();
        audio_valid = 1'b0;
        repeat (5) step();
        ov_before = ov_count;
        #2 RST = 1'b1;
        #1;
        chk(I_OUT == 12'd0, "midrot_reset_I", int'($signed(I_OUT)), 0);
        chk(audio_ready == 1'b0, "midrot_reset_ready", int'(audio_ready), 0);
        #1 RST = 1'b0;
        step();
        chk(audio_ready == 1'b1, "ready_after_midrot_reset", int'(audio_ready), 1);
        repeat (25) step();
        chk(ov_count == ov_before, "no_strobe_for_aborted", ov_count - ov_before, 0);
        v = '{32'h4000_0000, 16'd0, 12'd0, 1'b0, 0, 2047};
        run_sample(v, ri, rq, lat);
        chk(lat == LAT, "latency_after_reset", lat, LAT);
        chk_tol("after_reset_I", ri, 0, TOL);
        chk_tol("after_reset_Q", rq, 2047, TOL);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_modulate.md
Name: fm_modulate

Overview:
Transmit-side counterpart of the receiver's I/Q demodulator and vector-mode CORDIC. It takes signed audio samples over a valid/ready handshake and advances a 32-bit phase accumulator by a frequency word derived from the audio (FM). It then runs an iterative rotate-mode CORDIC on a constant-amplitude vector to produce one complex baseband I/Q sample per audio sample. The output feeds the upconverter/DAC path of the return voice link.

Parameters:
INPUT_WIDTH, 12, signed audio sample width; INPUT_WIDTH+17 <= PH_BITS.
IQ_WIDTH, 12, signed I/Q output width.
PH_BITS, 32, phase accumulator and angle width; full circle = 2^PH_BITS.
ITERATIONS, 16, CORDIC micro-rotations, 1..PH_BITS-2.
AMPLITUDE, 1243, initial x magnitude; 1243*1.6468 ≈ 2047 full scale.

Ports:
clk_in  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-high reset.
LO_fre  input  PH_BITS  carrier/offset frequency word; sampled only at accept.
dev_gain  input  16  unsigned deviation gain; sampled only at accept.
phase_clr  input  1  zero the accumulator; honoured only at accept.
audio_in  input  INPUT_WIDTH  signed audio sample.
audio_valid  input  1  audio_in valid.
audio_ready  output  1  block can accept a sample.
I_OUT  output  IQ_WIDTH  signed in-phase output.
Q_OUT  output  IQ_WIDTH  signed quadrature output.
out_valid  output  1  one-cycle strobe; I_OUT/Q_OUT new.

Behaviour:
- Reset (async, RST=1): state IDLE, phase_acc=0, CORDIC regs=0, I_OUT=0, Q_OUT=0, out_valid=0, audio_ready=0 while RST high.
- Accept: in IDLE with RST low, audio_ready=1. Accept = audio_valid&&audio_ready at a rising edge.
- Frequency word at accept: fw = LO_fre + sext(audio_in * dev_gain). The product is signed, INPUT_WIDTH+16 bits, sign-extended to PH_BITS.
- Phase update at accept: phase_acc <= (phase_clr ? 0 : phase_acc) + fw, mod 2^PH_BITS. Wrap is silent, with no saturation.
- FSM:
  - IDLE: on accept go to LOAD; otherwise stay.
  - LOAD (1 cycle): quadrant pre-rotation from the top two phase bits. If phase_acc[MSB]^phase_acc[MSB-1], load x=-AMPLITUDE and z=phase_acc with MSB inverted (subtract 180°). Otherwise load x=+AMPLITUDE and z=phase_acc. Always y=0, iteration counter i=0. Go to ROT.
  - ROT (ITERATIONS cycles): d=+1 if z>=0 (signed), else -1. Update x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i, i++. Go to DONE after i = ITERATIONS-1.
  - DONE (1 cycle): I_OUT=sat(x), Q_OUT=sat(y), out_valid=1. Go to IDLE.
- Arithmetic: x/y are IQ_WIDTH+2 bits signed; shifts are arithmetic.
- atan table: atan_i = round(atan(2^-i)/(2π)*2^PH_BITS), constant ROM. atan_0 = 2^(PH_BITS-3).
- Saturation: sat() clamps to ±(2^(IQ_WIDTH-1)-1). -2^(IQ_WIDTH-1) is never output.
- Latency: acceptance in cycle k gives out_valid in cycle k+ITERATIONS+2, audio_ready=1 again in cycle k+ITERATIONS+3. Throughput is 1 sample per ITERATIONS+3 cycles.
- audio_ready=0 in LOAD/ROT/DONE. audio_valid, audio_in, LO_fre, dev_gain and phase_clr are ignored outside the accept edge. No skid buffer.
- I_OUT/Q_OUT hold between DONE cycles. out_valid is never high for two consecutive cycles.
- Reset mid-LOAD/ROT/DONE: everything returns to reset values immediately. No out_valid is produced for the aborted sample.

Test Plan:
- Reset: assert RST mid-cycle -> I_OUT=Q_OUT=0, out_valid=0, audio_ready=0 asynchronously. After release, audio_ready=1 on the next cycle.
- LO_fre=0, dev_gain=0, audio_in=0, one accept at cycle k -> out_valid only at k+18. I_OUT=2047±2, Q_OUT=0±2.
- LO_fre=2^30, gain 0, four accepts -> (I,Q) ≈ (0,2047), (-2047,0), (0,-2047), (2047,0) within ±3 LSB. The fifth accept repeats the first (wrap).
- LO_fre=2^30-2^24, audio_in=512, dev_gain=32768 -> fw=2^30, same four-point sequence as above. audio_in=-512 -> fw=2^30-2^25, matching the reference model within ±3 LSB.
- audio_valid held high continuously -> exactly one accept every 19 cycles. audio_ready low for 18 cycles after each accept. Samples presented while busy are not consumed.
- phase_clr=1 with accept after several 90° steps -> phase=fw, output (0,2047)±3. Pulse RST during ROT -> no out_valid, phase_acc=0 for the next sample.
